tipi_reg_sequencer: RTL and testbench

- FPGA-side master for the TIPI serial register bank (RD, RC, TD, TC). It replaces RPi GPIO bit-banging.
- Accepts single-byte transfer requests over a valid/ready handshake.
- Generates the `rpi_regsel`/`rpi_sclk`/`rpi_sle`/`rpi_sdata_out` sequences and captures `rpi_sdata_in`.
- Write requests go to RD/RC (RPi→TI latches). Read requests come from TD/TC (TI→RPi latches).

---
 rtl/tipi_reg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_tipi_reg_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_reg_sequencer.sv
// tipi_reg_sequencer
// FPGA-side master for the TIPI serial register bank (RD, RC, TD, TC).
// It takes one byte request at a time and runs the serial bank protocol:
// regsel / sclk / sle / sdata_out are driven, and sdata_in is captured.
// Writes shift a byte into RD/RC and latch it with sle.
// Reads parallel-load TD/TC with sle and then shift the byte out, MSB first.
//
// Ports
//   clk, rst                  system clock; asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_write, req_reg        direction and register (00 RD, 01 RC, 10 TD, 11 TC)
//   req_wdata                 byte to write, MSB first on the wire
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      read byte / illegal-request flag, valid with resp_valid
//   busy                      high whenever the sequencer is not idle
//   rpi_regsel, rpi_sclk,     serial bank interface; the bank shifts on the
//   rpi_sle, rpi_sdata_out,   rising edge of sclk
//   rpi_sdata_in
module tipi_reg_sequencer #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       busy,
  output logic [1:0] rpi_regsel,
  output logic       rpi_sclk,
  output logic       rpi_sdata_out,
  output logic       rpi_sle,
  input  logic       rpi_sdata_in
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SHIFT_LO, SHIFT_HI, LATCH, ERR, DONE
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKDIV - 1);

  state_t     state;
  logic [7:0] cnt;       // cycle within the current phase
  logic [2:0] bit_idx;   // bit slot 0..7
  logic       wr;        // latched direction
  logic       err_flag;  // latched illegal-request flag
  logic [7:0] shreg;     // outgoing bits, next bit at [7]
  logic [7:0] cap;       // incoming bits, shifted in MSB first
  logic       phase_end;
  logic       req_illegal;

  // Phase-end strobe and request legality decode.
  always_comb begin
    phase_end   = (cnt == LAST_CNT);
    // Writes may only target RD/RC (reg 0x), reads only TD/TC (reg 1x).
    req_illegal = req_write ? req_reg[1] : ~req_reg[1];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      bit_idx       <= 3'd0;
      wr            <= 1'b0;
      err_flag      <= 1'b0;
      shreg         <= 8'h00;
      cap           <= 8'h00;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 8'h00;
      rpi_regsel    <= 2'b00;
      rpi_sclk      <= 1'b0;
      rpi_sle       <= 1'b0;
      rpi_sdata_out <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            wr        <= req_write;
            err_flag  <= req_illegal;
            cnt       <= 8'd0;
            bit_idx   <= 3'd0;
            cap       <= 8'h00;
            // Reads keep sdata_out at 0 by shifting out an all-zero byte.
            shreg     <= req_write ? req_wdata : 8'h00;
            if (req_illegal) begin
              // Illegal requests never touch the bank pins.
              state <= ERR;
            end else begin
              rpi_regsel <= req_reg;
              state      <= SETUP;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (phase_end) begin
            cnt <= 8'd0;
            if (wr) begin
              rpi_sdata_out <= shreg[7];
              shreg         <= {shreg[6:0], 1'b0};
              state         <= SHIFT_LO;
            end else begin
              rpi_sle <= 1'b1;
              state   <= LOAD;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LOAD: begin
          if (phase_end) begin
            cnt     <= 8'd0;
            rpi_sle <= 1'b0;
            state   <= SHIFT_LO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            // Sample on the last LOW cycle, before the bank shifts on the rise.
            cap      <= {cap[6:0], rpi_sdata_in};
            cnt      <= 8'd0;
            rpi_sclk <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            cnt      <= 8'd0;
            rpi_sclk <= 1'b0;
            if (bit_idx == 3'd7) begin
              rpi_sdata_out <= 1'b0;
              if (wr) begin
                rpi_sle <= 1'b1;
                state   <= LATCH;
              end else begin
                state <= DONE;
              end
            end else begin
              bit_idx       <= bit_idx + 3'd1;
              rpi_sdata_out <= shreg[7];
              shreg         <= {shreg[6:0], 1'b0};
              state         <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LATCH: begin
          if (phase_end) begin
            cnt     <= 8'd0;
            rpi_sle <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR: begin
          state <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b1;
          resp_err   <= err_flag;
          resp_rdata <= (wr || err_flag) ? 8'h00 : cap;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          rpi_sclk  <= 1'b0;
          rpi_sle   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tipi_reg_sequencer.sv
module tb_tipi_reg_sequencer;

  localparam int CD_A = 4;
  localparam int CD_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write;
  logic [1:0] req_reg;
  logic [7:0] req_wdata;
  logic       use1 = 1'b0;     // 0: CLKDIV=4 instance active, 1: CLKDIV=1 instance
  logic       loopback = 1'b0; // bank model: TD loads from the RD latch
  logic [7:0] src_td = 8'h00, src_tc = 8'h00;

  always #5 clk = ~clk;

  // Outputs of the two instances.
  logic       a_ready, a_rv, a_err, a_busy, a_sclk, a_sdo, a_sle;
  logic [7:0] a_rdata;
  logic [1:0] a_regsel;
  logic       b_ready, b_rv, b_err, b_busy, b_sclk, b_sdo, b_sle;
  logic [7:0] b_rdata;
  logic [1:0] b_regsel;
  logic       rpi_sdata_in;

  wire       req_ready     = use1 ? b_ready  : a_ready;
  wire       resp_valid    = use1 ? b_rv     : a_rv;
  wire       resp_err      = use1 ? b_err    : a_err;
  wire [7:0] resp_rdata    = use1 ? b_rdata  : a_rdata;
  wire       busy          = use1 ? b_busy   : a_busy;
  wire [1:0] rpi_regsel    = use1 ? b_regsel : a_regsel;
  wire       rpi_sclk      = use1 ? b_sclk   : a_sclk;
  wire       rpi_sdata_out = use1 ? b_sdo    : a_sdo;
  wire       rpi_sle       = use1 ? b_sle    : a_sle;

  tipi_reg_sequencer #(.CLKDIV(CD_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~use1), .req_ready(a_ready),
    .req_write(req_write), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy),
    .rpi_regsel(a_regsel), .rpi_sclk(a_sclk), .rpi_sdata_out(a_sdo),
    .rpi_sle(a_sle), .rpi_sdata_in(rpi_sdata_in));

  tipi_reg_sequencer #(.CLKDIV(CD_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & use1), .req_ready(b_ready),
    .req_write(req_write), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy),
    .rpi_regsel(b_regsel), .rpi_sclk(b_sclk), .rpi_sdata_out(b_sdo),
    .rpi_sle(b_sle), .rpi_sdata_in(rpi_sdata_in));

  // ---------------- bank model ----------------
  logic [7:0] bank_sh = 8'h00;
  logic [7:0] rd_latch = 8'h5A, rc_latch = 8'hC0;
  int         sclk_rises = 0, sle_rises = 0, sclk_at_sle = 0;

  assign rpi_sdata_in = bank_sh[7];

  always @(posedge rpi_sle or posedge rpi_sclk) begin
    if (rpi_sle && !rpi_sclk) begin
      sle_rises++;
      sclk_at_sle = sclk_rises;
      case (rpi_regsel)
        2'b00:   rd_latch = bank_sh;
        2'b01:   rc_latch = bank_sh;
        2'b10:   bank_sh  = loopback ? rd_latch : src_td;
        default: bank_sh  = src_tc;
      endcase
    end else begin
      sclk_rises++;
      bank_sh = {bank_sh[6:0], rpi_sdata_out};
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int         cyc = 0, due = 0, acc_cnt = 0, resp_cnt = 0;
  int         last_acc_cyc = 0, last_resp_cyc = 0;
  logic [7:0] last_rdata;
  logic       last_err;
  logic [7:0] resp_log [0:63];
  logic       pending = 1'b0, exp_legal, exp_write;
  logic [1:0] exp_reg;
  logic [7:0] exp_rdata, exp_wdata;
  int         sclk_at_acc, sle_at_acc, sle_hi, cd;
  logic       busy_exp;

  // Scoreboard: expected response time/content from the request rules,
  // compared against the DUT one time unit after every clock edge.
  always @(posedge clk) begin
    cd = use1 ? CD_B : CD_A;
    cyc++;
    if (rst) begin
      pending = 1'b0;
    end else if (req_valid && req_ready) begin
      pending   = 1'b1;
      exp_write = req_write;
      exp_reg   = req_reg;
      exp_wdata = req_wdata;
      exp_legal = req_write ? !req_reg[1] : req_reg[1];
      due       = cyc + (exp_legal ? 18 * cd + 1 : 2);
      if (!exp_legal || req_write) exp_rdata = 8'h00;
      else if (req_reg == 2'b11)   exp_rdata = src_tc;
      else                         exp_rdata = loopback ? rd_latch : src_td;
      sclk_at_acc  = sclk_rises;
      sle_at_acc   = sle_rises;
      sle_hi       = 0;
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    #1;
    if (rst) begin
      chk("reset_outputs", 32'({req_ready, busy, resp_valid, resp_err, resp_rdata,
                               rpi_regsel, rpi_sclk, rpi_sle, rpi_sdata_out}), 32'h0001_0000);
    end else begin
      busy_exp = pending && (cyc < due);
      chk("resp_valid", 32'(resp_valid), 32'(pending && cyc == due));
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("req_ready", 32'(req_ready), 32'(!busy_exp));
      chk("sclk_sle_overlap", 32'(rpi_sclk && rpi_sle), 32'd0);
      if (!busy_exp) chk("idle_pins", 32'({rpi_sclk, rpi_sle, rpi_sdata_out}), 32'd0);
      if (busy_exp && exp_legal) chk("regsel", 32'(rpi_regsel), 32'(exp_reg));
      if (rpi_sle) sle_hi++;
      if (resp_valid) begin
        resp_log[resp_cnt % 64] = resp_rdata;
        last_rdata    = resp_rdata;
        last_err      = resp_err;
        last_resp_cyc = cyc;
        resp_cnt++;
      end
      if (pending && cyc == due) begin
        pending = 1'b0;
        chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        chk("resp_err", 32'(resp_err), 32'(!exp_legal));
        chk("sclk_rises", 32'(sclk_rises - sclk_at_acc), exp_legal ? 32'd8 : 32'd0);
        chk("sle_pulses", 32'(sle_rises - sle_at_acc), exp_legal ? 32'd1 : 32'd0);
        chk("sle_width", 32'(sle_hi), exp_legal ? 32'(cd) : 32'd0);
        if (exp_legal && !exp_write)
          chk("sle_before_sclk", 32'(sclk_at_sle), 32'(sclk_at_acc));
        if (exp_legal && exp_write)
          chk("latched_byte", 32'(exp_reg == 2'b00 ? rd_latch : rc_latch), 32'(exp_wdata));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_acc();
    int start = acc_cnt;
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != start) begin got = 1'b1; break; end
    end
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic send(input logic w, input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_reg = r; req_wdata = d;
    wait_acc();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int start = resp_cnt;
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (resp_cnt != start) begin got = 1'b1; break; end
      @(posedge clk); #2;
    end
    chk("response_timeout", 32'(got), 32'd1);
  endtask

  int         a1, a2, a3, r0, base_rises, sle_before;
  logic [7:0] rd_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_reg = 2'b00; req_wdata = 8'h00;
    #1;
    chk("reset_ready_immediate", 32'({req_ready, busy, rpi_sclk, rpi_sle}), 32'h8);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: write RC 0xA5
    send(1'b1, 2'b01, 8'hA5); wait_resp();
    chk("t1_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd73);
    chk("t1_rdata", 32'(last_rdata), 32'h00);
    chk("t1_err", 32'(last_err), 32'd0);
    chk("t1_rc_latch", 32'(rc_latch), 32'hA5);

    // 2: reads of TC / TD
    src_tc = 8'h3C;
    send(1'b0, 2'b11, 8'h00); wait_resp();
    chk("t2_tc_rdata", 32'(last_rdata), 32'h3C);
    chk("t2_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd73);
    src_td = 8'hFF;
    send(1'b0, 2'b10, 8'h00); wait_resp();
    chk("t2_td_ff", 32'(last_rdata), 32'hFF);
    src_td = 8'h00;
    send(1'b0, 2'b10, 8'h00); wait_resp();
    chk("t2_td_00", 32'(last_rdata), 32'h00);

    // 3: illegal combinations
    send(1'b1, 2'b10, 8'h55); wait_resp();
    chk("t3_wr_td_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd2);
    chk("t3_wr_td_err", 32'(last_err), 32'd1);
    chk("t3_wr_td_rdata", 32'(last_rdata), 32'h00);
    send(1'b0, 2'b01, 8'h00); wait_resp();
    chk("t3_rd_rc_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd2);
    chk("t3_rd_rc_err", 32'(last_err), 32'd1);

    // 4: reset during the 4th HIGH phase of a write to RD
    rd_before = rd_latch;
    sle_before = sle_rises;
    send(1'b1, 2'b00, 8'h81);
    base_rises = sclk_rises - 0;
    for (int i = 0; i < 400; i++) begin
      if (sclk_rises >= base_rises + 4) break;
      @(posedge clk); #2;
    end
    chk("t4_reached_4th_high", 32'(sclk_rises - base_rises >= 4), 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t4_async_reset", 32'({req_ready, busy, resp_valid, resp_err, resp_rdata,
                              rpi_regsel, rpi_sclk, rpi_sle, rpi_sdata_out}), 32'h0001_0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t4_rd_unchanged", 32'(rd_latch), 32'(rd_before));
    chk("t4_no_sle", 32'(sle_rises - sle_before), 32'd0);
    send(1'b1, 2'b00, 8'h7E); wait_resp();
    chk("t4_rd_new", 32'(rd_latch), 32'h7E);
    chk("t4_err", 32'(last_err), 32'd0);

    // 5: req_valid held, reads TD, TC, TD
    src_td = 8'h12; src_tc = 8'h34;
    r0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_reg = 2'b10;
    wait_acc(); a1 = last_acc_cyc; req_reg = 2'b11;
    wait_acc(); a2 = last_acc_cyc; req_reg = 2'b10;
    wait_acc(); a3 = last_acc_cyc; req_valid = 1'b0;
    wait_resp();
    chk("t5_gap1", 32'(a2 - a1), 32'd74);
    chk("t5_gap2", 32'(a3 - a2), 32'd74);
    chk("t5_count", 32'(resp_cnt - r0), 32'd3);
    chk("t5_resp0", 32'(resp_log[r0 % 64]), 32'h12);
    chk("t5_resp1", 32'(resp_log[(r0 + 1) % 64]), 32'h34);
    chk("t5_resp2", 32'(resp_log[(r0 + 2) % 64]), 32'h12);

    // 6: CLKDIV=1 instance, write RD then loop it back through TD
    @(negedge clk);
    use1 = 1'b1; loopback = 1'b1;
    send(1'b1, 2'b00, 8'hC3); wait_resp();
    chk("t6_wr_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd19);
    chk("t6_rd_latch", 32'(rd_latch), 32'hC3);
    send(1'b0, 2'b10, 8'h00); wait_resp();
    chk("t6_rd_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd19);
    chk("t6_loopback", 32'(last_rdata), 32'hC3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
